// File: rtl/bus_arb_pkg.sv
// bus_arbiter shared types: FSM state encoding and requester indices.
// Optional feature macro: BUS_ARB_PRIORITY_EN (see bus_arbiter.sv).
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        TURN
    } arb_state_e;

    localparam int REQ_CTRL = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_ALU  = 2;
    localparam int REQ_RAX  = 3;
    localparam int REQ_RBX  = 4;
    localparam int REQ_RCX  = 5;
    localparam int REQ_RDX  = 6;

endpackage

// File: rtl/bus_arbiter_if.sv
// Shared CPU bus bundle between requesting units and bus_arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
    parameter int NUM_REQ = 7,
    parameter int DATA_W  = 8,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        grant;
    logic [IW-1:0]             grant_id;
    logic                      bus_valid;
    logic [DATA_W-1:0]         bus_out;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  grant_id,
        input  bus_valid,
        input  bus_out
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output grant_id,
        output bus_valid,
        output bus_out
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Rotating-priority encoder: first asserted req scanning from ptr upward,
// wrapping modulo N.
module rr_picker #(
    parameter int N  = 7,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] win_o
);

    function automatic logic [IW-1:0] wrap_idx(
        input logic [IW-1:0] p,
        input int            k
    );
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        found_o = 1'b0;
        win_o   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_i[wrap_idx(ptr_i, k)]) begin
                found_o = 1'b1;
                win_o   = wrap_idx(ptr_i, k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared CPU bus with hold limit and turnaround.
// BUS_ARB_PRIORITY_EN: control unit (index 0) always wins and is never preempted.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    bus_arbiter_if.slave bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gid_q, gid_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               valid_q, valid_d;

    logic               rr_found;
    logic [IW-1:0]      rr_win;
    logic [IW-1:0]      pick_id;
    logic [IW-1:0]      ptr_next;
    logic               owner_locked;
    logic               others_req;
    logic               expired;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (rr_found),
        .win_o   (rr_win)
    );

`ifdef BUS_ARB_PRIORITY_EN
    // Index 0 jumps the rotation and leaves ptr where it was.
    assign pick_id      = bus.req[REQ_CTRL] ? IW'(REQ_CTRL) : rr_win;
    assign owner_locked = (gid_q == IW'(REQ_CTRL));
    assign ptr_next     = bus.req[REQ_CTRL] ? ptr_q :
                          (rr_win == IW'(NUM_REQ - 1)) ? '0 : rr_win + 1'b1;
`else
    assign pick_id      = rr_win;
    assign owner_locked = 1'b0;
    assign ptr_next     = (rr_win == IW'(NUM_REQ - 1)) ? '0 : rr_win + 1'b1;
`endif

    assign others_req = |(bus.req & ~grant_q);
    assign expired    = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) &&
                        others_req && !owner_locked;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE, TURN: begin
                state_d = IDLE;
                if (rr_found) begin
                    state_d = OWNED;
                    grant_d = NUM_REQ'(1) << pick_id;
                    gid_d   = pick_id;
                    ptr_d   = ptr_next;
                    hold_d  = HW'(1);
                    valid_d = 1'b1;
                end
            end
            OWNED: begin
                // A drop coinciding with expiry lands in the same TURN.
                if (!bus.req[gid_q] || expired) begin
                    state_d = TURN;
                    grant_d = '0;
                    valid_d = 1'b0;
                end else if (MAX_HOLD != 0 && hold_q < HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = gid_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_out   = valid_q ?
                           bus.data_in[int'(gid_q) * DATA_W +: DATA_W] :
                           '0;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Owns the shared 8-bit CPU bus. It replaces ad-hoc multi-driver contention between the control unit, memory, ALU and the rax/rbx/rcx/rdx registers with a registered, one-hot grant. It uses round-robin arbitration, a bounded hold time per owner, and one dead turnaround cycle between owners. It sits between the requesting units and the bus. Only the granted requester's data reaches `bus_out`.

Parameters:
- NUM_REQ, 7, number of requesters (index 0 = control unit).
- DATA_W, 8, bus width.
- MAX_HOLD, 4, maximum consecutive OWNED cycles while others wait; 0 = unlimited.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request, level-sensitive.
- data_in  in  NUM_REQ*DATA_W  requester data; slice i = bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot registered grant; all zero when no owner.
- grant_id  out  $clog2(NUM_REQ)  index of the owner; valid only when bus_valid.
- bus_valid  out  1  high while a requester owns the bus.
- bus_out  out  DATA_W  data_in slice of the owner when bus_valid, else 0 (combinational from registered grant_id).

Behaviour:
- Reset (async, reset_n=0) clears all of the following immediately, including mid-OWNED:
  - state=IDLE, grant=0, grant_id=0, bus_valid=0, bus_out=0.
  - rr pointer ptr=0, hold_cnt=0.
- States: IDLE, OWNED, TURN.
- Arbitration:
  - Winner = first asserted req scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On grant to index i: ptr <= (i+1) mod NUM_REQ; hold_cnt <= 1.
- IDLE: if any req, grant the winner at the next edge → OWNED. Latency from req to grant = 1 cycle.
- OWNED: if req[grant_id]=0, clear grant at the next edge → TURN.
- OWNED, forced release: else if MAX_HOLD≠0, hold_cnt==MAX_HOLD, and some other req is high → TURN.
- OWNED, hold: else stay in OWNED; hold_cnt increments, saturating at MAX_HOLD.
- TURN: exactly one cycle with grant=0. req is sampled at the end of the cycle: winner → OWNED, none → IDLE. Minimum gap between two owners = 1 dead cycle.
- Owner drop and hold expiry in the same cycle: treated as a normal release (same result).
- A preempted owner whose req is still high re-competes. Because ptr has advanced past it, waiting requesters win first.
- With MAX_HOLD=0, a sole or persistent owner keeps the bus indefinitely.
- Invariants (must hold every cycle): grant is one-hot or zero, and bus_valid == |grant.

Optional Feature:
- BUS_ARB_PRIORITY_EN defined:
  - req[0] (control unit) wins every arbitration in which it is asserted, and ptr is not updated when index 0 is granted.
  - An owner with index 0 is never preempted by hold expiry.
  - Other owners are still preempted at MAX_HOLD, including when req[0] is the waiting request.
- Not defined: index 0 is an ordinary round-robin participant.

Decomposition:
- Shared package `bus_arb_pkg`:
  - `arb_state_e` {IDLE, OWNED, TURN}.
  - Requester index constants: REQ_CTRL=0, REQ_MEM=1, REQ_ALU=2, REQ_RAX=3, REQ_RBX=4, REQ_RCX=5, REQ_RDX=6.
- One sub-module: `rr_picker`, a combinational rotating-priority encoder. Inputs: req, ptr. Outputs: found, winner index.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles with req=7'h7F → grant=0, bus_valid=0, bus_out=0 throughout.
2. Single request, release and turnaround:
   - Stimulus: req[2]=1 at cycle 0, data_in[2]=8'hA5.
   - Cycle 1: grant=7'b0000100, grant_id=2, bus_out=8'hA5.
   - Drop req[2] at cycle 3 → grant=0 at cycle 4 (TURN), then IDLE at cycle 5.
3. Hold limit and rotation (MAX_HOLD=4, ptr=0):
   - Stimulus: req[1] and req[4] held high from cycle 0.
   - Cycles 1–4: grant=1. Cycle 5: TURN. Cycles 6–9: grant=4. Cycle 10: TURN. Cycle 11: grant=1.
4. Pointer wrap: after a grant to 5 (ptr=6), assert req[0] and req[3] at the TURN sample → 0 granted, ptr=1.
5. Reset mid-OWNED: grant=3; drop reset_n between clock edges → grant=0 and bus_valid=0 with no clock edge.
6. Priority macro (req[0] and req[3] held, MAX_HOLD=4):
   - BUS_ARB_PRIORITY_EN defined: 0 owns continuously, never preempted.
   - Not defined: ownership alternates 0,3,0,3 in 4-cycle slots separated by TURN.
